jzjpcc_mmio_uart_tx: RTL and testbench
======================================

# jzjpcc_mmio_uart_tx

Memory-mapped UART transmitter that sits on the peripheral side of the core's MMIO port pair. It consumes one core MMIO output word as a command register and drives one core MMIO input word as a status register. Bytes submitted by software are buffered in a small FIFO and serialised 8N1, LSB first, on `txd`. Because MMIO has no write strobe, software signals each new byte by flipping a toggle bit; the block acknowledges by mirroring that toggle.

## Interface
- `CLOCKS_PER_BIT`, 868: clock cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH_LOG2`, 3: FIFO holds 2^FIFO_DEPTH_LOG2 bytes. Range 1..4.

- `clock`  in  1  sole clock, rising edge; same domain as the core.
- `reset`  in  1  asynchronous, active-low.
- `mmioCommand`  in  32  connect to one `mmioOutputs[n]`.
  - [7:0] data byte.
  - [8] push toggle.
  - [9] overflow-clear toggle.
  - [31:10] ignored.
- `mmioStatus`  out  32  connect to one `mmioInputs[m]`.
  - [0] push-ack toggle.
  - [1] FIFO full.
  - [2] FIFO empty.
  - [3] busy (FSM not IDLE).
  - [4] overflow, sticky.
  - [8+FIFO_DEPTH_LOG2:8] FIFO count.
  - All other bits 0.
- `txd`  out  1  serial output; idles high.

## Operation
- Internal registers:
  - `pushSeen` and `clrSeen`, each 1 bit.
  - FIFO with read/write pointers of FIFO_DEPTH_LOG2 bits (wrap modulo depth) and a count of FIFO_DEPTH_LOG2+1 bits.
  - 8-bit shift register, bit index counter 0..7, baud counter 0..CLOCKS_PER_BIT-1.
- Push request: `mmioCommand[8] != pushSeen` at a rising edge. At that edge:
  - `pushSeen` ← `mmioCommand[8]`, always.
  - If the FIFO is not full, or a pop occurs at the same edge, [7:0] is written at the write pointer.
  - Otherwise the byte is dropped and overflow ← 1.
- Overflow clear: `mmioCommand[9] != clrSeen` sets `clrSeen` ← bit 9 and overflow ← 0. A simultaneous new overflow wins, leaving overflow = 1.
- `mmioStatus[0]` = `pushSeen`. Software polls until ack equals the toggle it wrote, then checks overflow. All status bits are combinational from registers.
- TX state machine:
  - IDLE:
    - `txd` = 1.
    - If FIFO not empty: pop into shift register, clear baud counter → START.
  - START:
    - `txd` = 0 for CLOCKS_PER_BIT cycles.
    - On baud terminal count → DATA, bit index 0.
  - DATA:
    - `txd` = shift[0] for CLOCKS_PER_BIT cycles per bit.
    - On terminal count: shift right and increment index. After index 7 → STOP.
  - STOP:
    - `txd` = 1 for CLOCKS_PER_BIT cycles.
    - On terminal count, if FIFO not empty: pop → START (back-to-back, no idle bit).
    - Otherwise → IDLE.
- Pop and push at the same edge: count is unchanged and both pointers advance.
- Push into an empty FIFO: the byte is not popped at the same edge. It is popped at the next edge if the FSM is IDLE.
- `txd` is registered, glitch-free.

## Timing
- Reset (asserted, asynchronous) drives:
  - `txd` = 1, FSM IDLE, FIFO empty, count 0.
  - `pushSeen` = 0, `clrSeen` = 0, overflow = 0.
  - `mmioStatus` = 0x00000004.
- Reset mid-frame aborts the frame immediately: `txd` goes high and all queued bytes are lost.
- Push latency: status count/ack update on the edge that samples the changed toggle.
- Start bit: the first `txd` low occurs 2 edges after a push into an empty, idle block (push edge, then pop edge).
- Frame length is exactly 10·CLOCKS_PER_BIT cycles.
- Sustained throughput: one byte per 10·CLOCKS_PER_BIT cycles.
- Capacity: the shifter plus the FIFO can hold 2^FIFO_DEPTH_LOG2 + 1 bytes in flight.

## Test plan
1. Reset: hold `reset` low mid-stream → `txd`=1, `mmioStatus`=0x00000004. Release it; with no command change, `txd` stays 1 for 100 cycles.
2. Single byte, CLOCKS_PER_BIT=4: write 0x00000155.
   - Next edge: status ack=1, count=1.
   - Then: start 0, bits 1,0,1,0,1,0,1,0, stop 1; 4 cycles each, 40 cycles total.
   - Afterwards: busy=0, empty=1.
3. Back-to-back: push 0xA5 then 0x3C (toggle 1, 0) → stop bit of 0xA5 is followed directly by the start bit of 0x3C; total 80 cycles low-to-idle.
4. Overflow, depth 8: push 10 bytes on consecutive edges.
   - Result: 9 accepted (1 popped, 8 queued), full=1, overflow=1, ack equals the last toggle.
   - Flip bit 9 → overflow=0.
   - The 9 bytes are transmitted in order.
5. Full plus simultaneous pop: fill the FIFO during a frame. Issue a push on the STOP terminal-count edge → byte accepted, count stays 8, overflow stays 0.
6. Overflow-clear and overflow in the same cycle: full FIFO, flip bits 8 and 9 together → overflow=1.

Source files
------------

// File: rtl/jzjpcc_mmio_uart_tx_if.sv
// rtl/jzjpcc_mmio_uart_tx_if.sv - MMIO command/status word pair and serial line of the UART transmitter
interface jzjpcc_mmio_uart_tx_if;
  logic [31:0] mmioCommand;
  logic [31:0] mmioStatus;
  logic        txd;

  // Core side: writes the command word, reads status and observes the line
  modport master (
    output mmioCommand,
    input  mmioStatus,
    input  txd
  );

  // Peripheral side: the transmitter itself
  modport slave (
    input  mmioCommand,
    output mmioStatus,
    output txd
  );
endinterface

// File: rtl/jzjpcc_mmio_uart_tx.sv
// rtl/jzjpcc_mmio_uart_tx.sv - toggle-handshaked MMIO UART transmitter with byte FIFO, 8N1 LSB first
module jzjpcc_mmio_uart_tx #(
  parameter int CLOCKS_PER_BIT  = 868,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input logic                  clock,
  input logic                  reset,
  jzjpcc_mmio_uart_tx_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BW    = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BW-1:0]              BAUD_LAST  = BW'(CLOCKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state, state_d;

  logic                       push_seen, clr_seen, overflow;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic [7:0]                 shift, shift_d;
  logic [2:0]                 bit_idx, bit_idx_d;
  logic [BW-1:0]              baud, baud_d;
  logic                       txd_q, txd_d;
  logic                       pop, accept;
  logic                       push_req, clr_req;
  logic                       fifo_full, fifo_empty, baud_tc;
  logic [31:0]                status;
  logic                       unused_cmd_bits;

  // A flipped toggle bit, relative to what was last seen, is a new request
  assign push_req   = bus.mmioCommand[8] != push_seen;
  assign clr_req    = bus.mmioCommand[9] != clr_seen;
  assign fifo_full  = count == COUNT_FULL;
  assign fifo_empty = count == '0;
  assign baud_tc    = baud == BAUD_LAST;
  // A full FIFO still takes a byte when the shifter frees a slot on the same edge
  assign accept     = push_req && (!fifo_full || pop);
  assign unused_cmd_bits = ^bus.mmioCommand[31:10];

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // FSM next state: STOP chains straight into START when more bytes are queued
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (baud_tc) state_d = DATA;
      DATA:    if (baud_tc && bit_idx == 3'd7) state_d = STOP;
      STOP:    if (baud_tc) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop, shifter/counter updates and the next line level
  always_comb begin
    pop       = 1'b0;
    shift_d   = shift;
    bit_idx_d = bit_idx;
    baud_d    = baud_tc ? '0 : baud + BW'(1);
    case (state)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
        end
      end
      START: begin
        if (baud_tc) bit_idx_d = '0;
      end
      DATA: begin
        if (baud_tc) begin
          shift_d   = {1'b0, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (baud_tc && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
        end
      end
      default: ;
    endcase
    // Line level follows the state being entered so txd leaves a flop
    txd_d = (state_d == DATA) ? shift_d[0] : (state_d != START);
  end

  // Datapath, FIFO bookkeeping and handshake registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift     <= '0;
      bit_idx   <= '0;
      baud      <= '0;
      txd_q     <= 1'b1;
      push_seen <= 1'b0;
      clr_seen  <= 1'b0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      shift     <= shift_d;
      bit_idx   <= bit_idx_d;
      baud      <= baud_d;
      txd_q     <= txd_d;
      push_seen <= bus.mmioCommand[8];
      clr_seen  <= bus.mmioCommand[9];
      // A dropped byte on the same edge as a clear leaves overflow set
      if (push_req && !accept) overflow <= 1'b1;
      else if (clr_req)        overflow <= 1'b0;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= bus.mmioCommand[7:0];
  end

  // Status word assembled directly from registers
  always_comb begin
    status                           = '0;
    status[0]                        = push_seen;
    status[1]                        = fifo_full;
    status[2]                        = fifo_empty;
    status[3]                        = state != IDLE;
    status[4]                        = overflow;
    status[8+FIFO_DEPTH_LOG2:8]      = count;
  end

  assign bus.mmioStatus = status;
  assign bus.txd        = txd_q;

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// tb/tb_jzjpcc_mmio_uart_tx.sv - self-checking bench for the MMIO UART transmitter
module tb_jzjpcc_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int L     = 3;
  localparam int DEPTH = 1 << L;
  localparam int FRAME = 10 * CPB;
  localparam int CW    = L + 1;

  logic clock;
  logic reset;
  jzjpcc_mmio_uart_tx_if bus_if ();

  jzjpcc_mmio_uart_tx #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(L)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: queue of bytes waiting, sticky flags, and the cycle at
  // which the frame currently on the line finishes its stop bit.
  logic [7:0]  mq[$];
  logic [7:0]  exp_q[$];
  logic [9:0]  rx_q[$];
  logic        m_push_seen, m_clr_seen, m_ov;
  int          cyc, frame_end;
  logic [31:0] cmd_now;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Line receiver: samples every bit in its middle and queues {stop, data, start}
  initial begin
    logic [9:0] fr;
    forever begin
      @(posedge clock); #1;
      if (reset === 1'b1 && bus_if.txd === 1'b0) begin
        repeat (CPB / 2) begin @(posedge clock); #1; end
        fr[0] = bus_if.txd;
        for (int k = 1; k < 10; k++) begin
          repeat (CPB) begin @(posedge clock); #1; end
          fr[k] = bus_if.txd;
        end
        rx_q.push_back(fr);
      end
    end
  end

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s           = '0;
    s[0]        = m_push_seen;
    s[1]        = mq.size() == DEPTH;
    s[2]        = mq.size() == 0;
    s[3]        = cyc < frame_end;
    s[4]        = m_ov;
    s[8+L:8]    = CW'(mq.size());
    return s;
  endfunction

  function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
    logic [9:0]       fr;
    logic [FRAME-1:0] w;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) w[i] = fr[i / CPB];
    return w;
  endfunction

  function automatic int rx_errors();
    int e;
    e = 0;
    if (rx_q.size() != exp_q.size()) e = 1;
    else foreach (rx_q[i]) if (rx_q[i] !== {1'b1, exp_q[i], 1'b0}) e++;
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_push_seen = 1'b0;
    m_clr_seen  = 1'b0;
    m_ov        = 1'b0;
    frame_end   = cyc;
  endtask

  // One clock edge with the given command word, advancing the model alongside
  task automatic step(input logic [31:0] cmd);
    bit preq, creq, pop, acc;
    bus_if.mmioCommand = cmd;
    @(posedge clock);
    cyc++;
    preq = cmd[8] != m_push_seen;
    creq = cmd[9] != m_clr_seen;
    pop  = (mq.size() != 0) && (cyc >= frame_end);
    acc  = preq && ((mq.size() < DEPTH) || pop);
    if (pop) begin
      void'(mq.pop_front());
      frame_end = cyc + FRAME;
    end
    if (acc) begin
      mq.push_back(cmd[7:0]);
      exp_q.push_back(cmd[7:0]);
    end
    if (preq && !acc) m_ov = 1'b1;
    else if (creq)    m_ov = 1'b0;
    m_push_seen = cmd[8];
    m_clr_seen  = cmd[9];
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    cmd_now[8]   = ~cmd_now[8];
    cmd_now[7:0] = b;
    step(cmd_now);
  endtask

  task automatic drain();
    for (int i = 0; i < 20000; i++) begin
      if (mq.size() == 0 && cyc > frame_end + 4) break;
      step(cmd_now);
    end
  endtask

  task automatic test_reset();
    bit bad;
    cmd_now = '0;
    bus_if.mmioCommand = '0;
    cyc = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (bus_if.txd !== 1'b1) begin
      tests_failed++; $display("FAIL reset_txd: got %b want 1", bus_if.txd);
    end
    tests_run++;
    if (bus_if.mmioStatus !== 32'h4) begin
      tests_failed++; $display("FAIL reset_status: got %h want 00000004", bus_if.mmioStatus);
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    repeat (17) step(cmd_now);
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus_if.txd !== 1'b1 || bus_if.mmioStatus !== 32'h4) begin
      tests_failed++;
      $display("FAIL reset_midframe: got txd %b status %h want 1 00000004", bus_if.txd, bus_if.mmioStatus);
    end
    cmd_now = '0;
    bus_if.mmioCommand = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(cmd_now);
      if (bus_if.txd !== 1'b1) bad = 1'b1;
    end
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idle_line: txd dropped after reset, want 1 for 100 cycles");
    end
    rx_q.delete();
  endtask

  task automatic test_single_byte();
    logic [FRAME-1:0] cap;
    int e;
    cmd_now = 32'h0000_0155;
    step(cmd_now);
    tests_run++;
    if (bus_if.mmioStatus !== 32'h101 || bus_if.mmioStatus !== model_status()) begin
      tests_failed++; $display("FAIL single_ack: got %h want 00000101", bus_if.mmioStatus);
    end
    for (int i = 0; i < FRAME; i++) begin
      step(cmd_now);
      cap[i] = bus_if.txd;
    end
    tests_run++;
    if (cap !== frame_bits(8'h55)) begin
      tests_failed++; $display("FAIL single_wave: got %h want %h", cap, frame_bits(8'h55));
    end
    step(cmd_now);
    tests_run++;
    if (bus_if.txd !== 1'b1 || bus_if.mmioStatus !== 32'h5) begin
      tests_failed++; $display("FAIL single_idle: got txd %b status %h want 1 00000005", bus_if.txd, bus_if.mmioStatus);
    end
    drain();
    e = rx_errors();
    tests_run++;
    if (e !== 0) begin
      tests_failed++; $display("FAIL single_rx: got %0d frames %0d bad want %0d", rx_q.size(), e, exp_q.size());
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [2*FRAME-1:0] cap;
    logic [2*FRAME-1:0] want;
    push_byte(8'hA5);
    push_byte(8'h3C);
    cap[0] = bus_if.txd;
    for (int i = 1; i < 2 * FRAME; i++) begin
      step(cmd_now);
      cap[i] = bus_if.txd;
    end
    want = {frame_bits(8'h3C), frame_bits(8'hA5)};
    tests_run++;
    if (cap !== want) begin
      tests_failed++; $display("FAIL b2b_wave: got %h want %h", cap, want);
    end
    step(cmd_now);
    tests_run++;
    if (bus_if.txd !== 1'b1 || bus_if.mmioStatus[3] !== 1'b0 || bus_if.mmioStatus !== model_status()) begin
      tests_failed++; $display("FAIL b2b_idle: got txd %b status %h want 1 %h", bus_if.txd, bus_if.mmioStatus, model_status());
    end
    drain();
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    int e;
    for (int i = 0; i < 10; i++) push_byte(8'($urandom));
    tests_run++;
    if (bus_if.mmioStatus[1] !== 1'b1 || bus_if.mmioStatus[4] !== 1'b1 ||
        bus_if.mmioStatus[8+L:8] !== CW'(DEPTH) || bus_if.mmioStatus[0] !== cmd_now[8] ||
        bus_if.mmioStatus !== model_status()) begin
      tests_failed++; $display("FAIL ovf_status: got %h want %h", bus_if.mmioStatus, model_status());
    end
    cmd_now[9] = ~cmd_now[9];
    step(cmd_now);
    tests_run++;
    if (bus_if.mmioStatus[4] !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_clear: got overflow %b want 0", bus_if.mmioStatus[4]);
    end
    drain();
    e = rx_errors();
    tests_run++;
    if (e !== 0 || rx_q.size() !== 9) begin
      tests_failed++; $display("FAIL ovf_rx: got %0d frames %0d bad want 9", rx_q.size(), e);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_pop();
    int e;
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
    tests_run++;
    if (bus_if.mmioStatus[1] !== 1'b1) begin
      tests_failed++; $display("FAIL fullpop_prefill: got full %b want 1", bus_if.mmioStatus[1]);
    end
    while (cyc + 1 < frame_end) step(cmd_now);
    push_byte(8'($urandom));
    tests_run++;
    if (bus_if.mmioStatus[8+L:8] !== CW'(DEPTH) || bus_if.mmioStatus[4] !== 1'b0 ||
        bus_if.mmioStatus !== model_status()) begin
      tests_failed++; $display("FAIL fullpop_status: got %h want %h", bus_if.mmioStatus, model_status());
    end
    drain();
    e = rx_errors();
    tests_run++;
    if (e !== 0 || rx_q.size() !== DEPTH + 2) begin
      tests_failed++; $display("FAIL fullpop_rx: got %0d frames %0d bad want %0d", rx_q.size(), e, DEPTH + 2);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_clear_vs_overflow();
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
    cmd_now[9:8]  = ~cmd_now[9:8];
    cmd_now[7:0]  = 8'($urandom);
    step(cmd_now);
    tests_run++;
    if (bus_if.mmioStatus[4] !== 1'b1 || bus_if.mmioStatus !== model_status()) begin
      tests_failed++; $display("FAIL clr_ovf_race: got %h want overflow 1 (%h)", bus_if.mmioStatus, model_status());
    end
    cmd_now[9] = ~cmd_now[9];
    step(cmd_now);
    tests_run++;
    if (bus_if.mmioStatus[4] !== 1'b0) begin
      tests_failed++; $display("FAIL clr_after_race: got overflow %b want 0", bus_if.mmioStatus[4]);
    end
    drain();
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int e;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        cmd_now[8]   = ~cmd_now[8];
        cmd_now[7:0] = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) cmd_now[9] = ~cmd_now[9];
      cmd_now[31:10] = 22'($urandom);
      step(cmd_now);
      tests_run++;
      if (bus_if.mmioStatus !== model_status()) begin
        tests_failed++; $display("FAIL rand_status cyc %0d: got %h want %h", cyc, bus_if.mmioStatus, model_status());
      end
    end
    drain();
    e = rx_errors();
    tests_run++;
    if (e !== 0) begin
      tests_failed++; $display("FAIL rand_rx: got %0d frames %0d bad want %0d", rx_q.size(), e, exp_q.size());
    end
    rx_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_clear_vs_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
